// File: rtl/regfile_sb.sv
// Two-read/one-write register file with per-register busy scoreboard, registered reads and write bypass.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (no write, no reserve, no bypass).
module regfile_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WREN,
  input  logic [ADDR_W-1:0] INaddr,
  input  logic [DATA_W-1:0] IN,
  input  logic              RESV,
  input  logic [ADDR_W-1:0] RESVaddr,
  input  logic              RDEN,
  input  logic [ADDR_W-1:0] OUT1addr,
  input  logic [ADDR_W-1:0] OUT2addr,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              RVALID,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  eb;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              resv_ok;
  logic              accept;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wr_ok   = WREN && !(ZERO_EN && (INaddr == '0));
  assign resv_ok = RESV && !(ZERO_EN && (RESVaddr == '0));

  // A write this cycle releases its register so a waiting read can proceed now.
  always_comb begin
    eb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eb[i] = busy[i] && !(WREN && (INaddr == ADDR_W'(i)));
    end
  end

  assign BUSY   = RDEN && (eb[OUT1addr] || eb[OUT2addr]);
  assign accept = RDEN && !BUSY;

  always_comb begin
    rd1 = regs[OUT1addr];
    if (ZERO_EN && (OUT1addr == '0)) begin
      rd1 = '0;
    end else if (WREN && (INaddr == OUT1addr)) begin
      rd1 = IN;
    end
  end

  always_comb begin
    rd2 = regs[OUT2addr];
    if (ZERO_EN && (OUT2addr == '0)) begin
      rd2 = '0;
    end else if (WREN && (INaddr == OUT2addr)) begin
      rd2 = IN;
    end
  end

  // Reserve is applied after the write clear so a same-cycle reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[INaddr] = 1'b0;
    end
    if (resv_ok) begin
      busy_nxt[RESVaddr] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy   <= '0;
      OUT1   <= '0;
      OUT2   <= '0;
      RVALID <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[INaddr] <= IN;
      end
      busy   <= busy_nxt;
      RVALID <= accept;
      if (accept) begin
        OUT1 <= rd1;
        OUT2 <= rd2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed plan checks plus randomized traffic
// compared every cycle against a behavioural model (honours REGFILE_ZERO_REG_EN).
module tb_regfile_sb;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          WREN = 1'b0;
  logic [AW-1:0] INaddr = '0;
  logic [DW-1:0] IN = '0;
  logic          RESV = 1'b0;
  logic [AW-1:0] RESVaddr = '0;
  logic          RDEN = 1'b0;
  logic [AW-1:0] OUT1addr = '0;
  logic [AW-1:0] OUT2addr = '0;
  logic [DW-1:0] OUT1;
  logic [DW-1:0] OUT2;
  logic          RVALID;
  logic          BUSY;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .WREN(WREN), .INaddr(INaddr), .IN(IN),
    .RESV(RESV), .RESVaddr(RESVaddr), .RDEN(RDEN), .OUT1addr(OUT1addr),
    .OUT2addr(OUT2addr), .OUT1(OUT1), .OUT2(OUT2), .RVALID(RVALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: storage array, busy flags and last read result.
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] m_out1, m_out2;
  bit            m_rvalid;
  bit            m_stalled;

  function automatic bit m_eb(int a);
    return m_busy[a] && !(WREN && int'(INaddr) == a);
  endfunction

  function automatic bit m_stall();
    return RDEN && (m_eb(int'(OUT1addr)) || m_eb(int'(OUT2addr)));
  endfunction

  function automatic logic [DW-1:0] m_read(int a);
    if (ZERO && a == 0) return '0;
    if (WREN && int'(INaddr) == a) return IN;
    return m_reg[a];
  endfunction

  always @(posedge CLK or negedge RESET) begin
    automatic bit acc;
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_out1 = '0;
      m_out2 = '0;
      m_rvalid = 1'b0;
      m_stalled = 1'b0;
    end else begin
      acc = RDEN && !m_stall();
      if (acc) begin
        m_out1 = m_read(int'(OUT1addr));
        m_out2 = m_read(int'(OUT2addr));
      end
      m_rvalid = acc;
      m_stalled = RDEN && !acc;
      if (WREN && !(ZERO && INaddr == 0)) begin
        m_reg[INaddr] = IN;
        m_busy[INaddr] = 1'b0;
      end
      if (RESV && !(ZERO && RESVaddr == 0)) m_busy[RESVaddr] = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("cmp_OUT1", OUT1, m_out1);
      chk("cmp_OUT2", OUT2, m_out2);
      chk("cmp_RVALID", RVALID, m_rvalid);
      chk("cmp_BUSY", BUSY, m_stall());
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_on = 1'b1;
    chk("rst_OUT1", OUT1, 0);
    chk("rst_OUT2", OUT2, 0);
    chk("rst_RVALID", RVALID, 0);
    chk("rst_BUSY", BUSY, 0);
    RESET = 1'b1;

    // basic writes then dual read
    WREN = 1; INaddr = 3; IN = 8'h5A; step();
    INaddr = 6; IN = 8'hC3; step();
    WREN = 0; RDEN = 1; OUT1addr = 3; OUT2addr = 6; step();
    chk("rd_OUT1", OUT1, 8'h5A);
    chk("rd_OUT2", OUT2, 8'hC3);
    chk("rd_RVALID", RVALID, 1);
    RDEN = 0; step();
    chk("idle_RVALID", RVALID, 0);
    chk("idle_OUT1_held", OUT1, 8'h5A);

    // bypass
    WREN = 1; INaddr = 2; IN = 8'h77; RDEN = 1; OUT1addr = 2; OUT2addr = 3; step();
    chk("byp_OUT1", OUT1, 8'h77);
    chk("byp_RVALID", RVALID, 1);
    WREN = 0; RDEN = 0;

    // scoreboard stall then release by write
    RESV = 1; RESVaddr = 4; step();
    RESV = 0; RDEN = 1; OUT1addr = 3; OUT2addr = 4; #1;
    chk("sb_BUSY", BUSY, 1);
    repeat (3) begin
      step();
      chk("sb_RVALID_stall", RVALID, 0);
    end
    WREN = 1; INaddr = 4; IN = 8'h99; #1;
    chk("sb_BUSY_release", BUSY, 0);
    step();
    chk("sb_OUT2", OUT2, 8'h99);
    chk("sb_RVALID", RVALID, 1);
    WREN = 0; RDEN = 0;

    // reserve and write same register, same cycle: stays busy
    RESV = 1; RESVaddr = 5; WREN = 1; INaddr = 5; IN = 8'h11; step();
    RESV = 0; WREN = 0; RDEN = 1; OUT1addr = 5; OUT2addr = 5; #1;
    chk("rw5_BUSY", BUSY, 1);
    step();
    chk("rw5_RVALID", RVALID, 0);
    WREN = 1; INaddr = 5; IN = 8'h22; #1;
    chk("rw5_BUSY_release", BUSY, 0);
    step();
    chk("rw5_OUT1", OUT1, 8'h22);
    chk("rw5_OUT2", OUT2, 8'h22);
    chk("rw5_RVALID", RVALID, 1);
    WREN = 0; RDEN = 0;

    // reset during a stall
    RESV = 1; RESVaddr = 1; step();
    RESV = 0; RDEN = 1; OUT1addr = 1; OUT2addr = 1; step();
    chk("rs_stall_RVALID", RVALID, 0);
    chk("rs_stall_BUSY", BUSY, 1);
    RESET = 0; #1;
    chk("rs_RVALID", RVALID, 0);
    chk("rs_OUT1", OUT1, 0);
    chk("rs_OUT2", OUT2, 0);
    #2 RESET = 1;
    step();
    chk("rs_after_RVALID", RVALID, 1);
    chk("rs_after_OUT1", OUT1, 0);
    RDEN = 0;

    // register 0 behaviour
    WREN = 1; INaddr = 0; IN = 8'hFF; step();
    WREN = 0; RDEN = 1; OUT1addr = 0; OUT2addr = 0; step();
    chk("r0_OUT1", OUT1, ZERO ? 8'h00 : 8'hFF);
    RDEN = 0; RESV = 1; RESVaddr = 0; step();
    RESV = 0; RDEN = 1; #1;
    chk("r0_BUSY", BUSY, ZERO ? 0 : 1);
    step();
    chk("r0_RVALID", RVALID, ZERO ? 1 : 0);
    RDEN = 0;

    // randomized traffic; reads are held while stalled
    for (int n = 0; n < 3000; n++) begin
      WREN = ($urandom_range(0, 1) == 1);
      INaddr = AW'($urandom_range(0, DEPTH - 1));
      IN = DW'($urandom);
      RESV = ($urandom_range(0, 3) == 0);
      RESVaddr = AW'($urandom_range(0, DEPTH - 1));
      if (!m_stalled) begin
        RDEN = ($urandom_range(0, 2) != 0);
        OUT1addr = AW'($urandom_range(0, DEPTH - 1));
        OUT2addr = ($urandom_range(0, 4) == 0) ? OUT1addr : AW'($urandom_range(0, DEPTH - 1));
      end
      step();
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/one-write register file with a per-register busy scoreboard, registered read outputs and write-to-read bypass. It supersedes the fixed 8x8 register file in the datapath. Multi-cycle producers reserve a destination register so that dependent reads stall instead of returning stale data. All state sits on a single clock edge.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-low reset
- WREN  input  1  write enable
- INaddr  input  ADDR_W  write address
- IN  input  DATA_W  write data
- RESV  input  1  reserve request: mark RESVaddr busy
- RESVaddr  input  ADDR_W  register to reserve
- RDEN  input  1  read request for both read ports
- OUT1addr  input  ADDR_W  read port 1 address
- OUT2addr  input  ADDR_W  read port 2 address
- OUT1  output  DATA_W  read port 1 data, registered
- OUT2  output  DATA_W  read port 2 data, registered
- RVALID  output  1  OUT1/OUT2 hold the data for the read accepted on the previous edge
- BUSY  output  1  combinational; RDEN is blocked this cycle

## Operation
- Reset (RESET=0, asynchronous): all registers clear to 0; all busy bits clear to 0; OUT1=0, OUT2=0, RVALID=0. BUSY then reflects only the current inputs.
- Write: on an edge with WREN=1, the register at INaddr takes IN and busy[INaddr] clears.
- Reserve: on an edge with RESV=1, busy[RESVaddr] sets.
  - RESV and WREN on the same address in the same cycle: the bit ends set, because the reserve is a new in-flight producer.
  - Reserving an already-busy register leaves it set; there is no counting.
- Effective busy (eb[a]) = busy[a] AND NOT (WREN AND INaddr==a). A write in the current cycle releases its register for same-cycle reads.
- BUSY = RDEN AND (eb[OUT1addr] OR eb[OUT2addr]).
- Read accept = RDEN AND NOT BUSY. On acceptance, each port captures its data at the next edge:
  - IN if WREN=1 and INaddr equals that port's address (bypass, write-first);
  - otherwise the stored register.
  - RVALID=1 for exactly that following cycle.
- No acceptance: OUT1 and OUT2 hold their last values and RVALID=0. The requester holds RDEN and the addresses until the read is accepted.
- A same-cycle reserve does not affect the read in that cycle, because eb uses the pre-edge busy bits.
- Both ports reading the same address is legal; both return identical data.

## Timing
- Write to storage: 1 edge.
- Read latency: data and RVALID appear 1 cycle after the accepting edge. Back-to-back accepted reads give RVALID high continuously.
- Stall: BUSY is combinational from RDEN, the read addresses, the busy bits, WREN and INaddr. There is no registered state for stalls.
- Reset asserted mid-operation: the pending read is dropped (RVALID=0 immediately); all reservations are lost.
- Reset release: the first accept is possible on the first rising edge after RESET goes high.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - Register 0 is hardwired to 0; writes to address 0 are ignored.
  - RESV on address 0 is ignored, so busy[0] is always 0.
  - Reads of address 0 return 0; no bypass for address 0.
- Undefined: register 0 is an ordinary register.

## Test plan
- Reset, then write 0x5A to r3 and 0xC3 to r6; RDEN with OUT1addr=3, OUT2addr=6 -> next cycle OUT1=0x5A, OUT2=0xC3, RVALID=1; next cycle with RDEN=0 -> RVALID=0, outputs held.
- Bypass: same cycle WREN, INaddr=2, IN=0x77, RDEN with OUT1addr=2 -> next cycle OUT1=0x77, RVALID=1.
- Scoreboard: RESV r4; next cycle RDEN with OUT2addr=4 -> BUSY=1, RVALID stays 0 for 3 held cycles; then WREN r4=0x99 in the same cycle as the held read -> BUSY=0, next cycle OUT2=0x99, RVALID=1.
- Simultaneous RESV and WREN on r5 -> busy[5] remains set; a subsequent read of r5 stalls until a later write.
- Reset mid-stall: r1 busy, RDEN held, RESET pulsed low -> RVALID=0, OUT1=OUT2=0; after release the read of r1 is accepted (data 0).
- With REGFILE_ZERO_REG_EN: write 0xFF to r0, RESV r0, read r0 -> no stall, OUT1=0. Without the macro: OUT1=0xFF after the write, and the read stalls after RESV.
